// File: rtl/tile_pkg.sv
// ---------------------------------------------------------------------------
// tile_pkg
//   Shared constants for the 5x5 systolic tile scheduler slice.
//   - FSM state encoding used by tile_sched (legacy-compatible constants)
//   - Tile calibration-state codes driven onto i_cal_state of top_tile
//   - Default tile geometry and the drain length derived from it
// ---------------------------------------------------------------------------
package tile_pkg;

  // Scheduler FSM states
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_STREAM = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_OUT    = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  // Tile cal_state codes
  localparam logic [1:0] CAL_IDLE   = 2'b00;
  localparam logic [1:0] CAL_LOAD   = 2'b01;
  localparam logic [1:0] CAL_STREAM = 2'b10;
  localparam logic [1:0] CAL_DRAIN  = 2'b11;

  // Default tile geometry
  localparam int unsigned DEF_ROWS  = 5;
  localparam int unsigned DEF_COLS  = 5;
  localparam int unsigned DRAIN_CYC = DEF_ROWS + DEF_COLS - 1;

  // Cycles needed for the last partial sum to ripple out of a ROWSxCOLS array
  function automatic int unsigned drain_cycles(input int unsigned rows,
                                               input int unsigned cols);
    return rows + cols - 1;
  endfunction

endpackage

// File: rtl/sched_phase_cnt.sv
// ---------------------------------------------------------------------------
// sched_phase_cnt
//   Loadable down-counter used to time the scheduler phases. Loading N makes
//   o_tc assert after N further cycles, i.e. a phase of N+1 cycles ends on
//   the cycle o_tc is high. The count parks at zero once reached.
// Ports
//   clk, rst     clock, async active-high reset
//   i_load       load strobe (takes priority over counting)
//   i_load_val   value to load (phase length minus one)
//   o_tc         terminal count: counter is zero
// ---------------------------------------------------------------------------
module sched_phase_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/tile_sched.sv
// ---------------------------------------------------------------------------
// tile_sched
//   Pass-level scheduler for the 5x5 systolic tile. For every pass of a job
//   it walks the tile through LOAD -> STREAM -> DRAIN, strobes the buffer
//   read side, captures the column accumulators at the end of DRAIN and
//   offers them on a valid/ready port. All outputs are registered.
//
// Optional feature (macro TILE_SCHED_PERF_EN):
//   adds o_stall_cnt[15:0], a saturating count of OUT cycles spent waiting
//   on i_res_ready; cleared on reset and on every accepted start.
//
// Ports
//   clk, rst         clock, async active-high reset
//   i_start          job start pulse, accepted only in IDLE
//   i_layer_state    layer code, latched on accepted start
//   i_num_pass       passes in the job, latched on accepted start
//   i_pass_len       STREAM cycles per pass (0 behaves as 1), latched
//   o_busy           job in progress (LOAD..OUT)
//   o_done           one-cycle job-complete pulse
//   o_en_tf          tile enable (LOAD/STREAM/DRAIN)
//   o_cal_state      tile phase code (see tile_pkg CAL_*)
//   o_layer_state    latched layer code to the tile
//   o_rd_en          buffer read strobe (LOAD/STREAM)
//   i_acc_pp         tile column accumulators
//   o_res_valid      result valid
//   i_res_ready      downstream ready
//   o_res_data       captured pass result, stable while valid
//   o_pass_idx       current pass, 0-based
//   o_stall_cnt      (TILE_SCHED_PERF_EN only) result back-pressure cycles
// ---------------------------------------------------------------------------
module tile_sched
  import tile_pkg::*;
#(
  parameter int unsigned AK_BW  = 20,
  parameter int unsigned ROWS   = 5,
  parameter int unsigned COLS   = 5,
  parameter int unsigned CNT_BW = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [2:0]            i_layer_state,
  input  logic [CNT_BW-1:0]     i_num_pass,
  input  logic [CNT_BW-1:0]     i_pass_len,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_en_tf,
  output logic [1:0]            o_cal_state,
  output logic [2:0]            o_layer_state,
  output logic                  o_rd_en,
  input  logic [AK_BW*COLS-1:0] i_acc_pp,
  output logic                  o_res_valid,
  input  logic                  i_res_ready,
  output logic [AK_BW*COLS-1:0] o_res_data,
`ifdef TILE_SCHED_PERF_EN
  output logic [15:0]           o_stall_cnt,
  output logic [CNT_BW-1:0]     o_pass_idx
`else
  output logic [CNT_BW-1:0]     o_pass_idx
`endif
);

  localparam logic [CNT_BW-1:0] LOAD_LAST  = CNT_BW'(ROWS - 1);
  localparam logic [CNT_BW-1:0] DRAIN_LAST = CNT_BW'(drain_cycles(ROWS, COLS) - 1);

  logic [2:0]        r_state;
  logic [2:0]        w_nxt_state;
  logic [CNT_BW-1:0] r_num_pass;
  logic [CNT_BW-1:0] r_pass_len;
  logic              w_cnt_load;
  logic [CNT_BW-1:0] w_cnt_val;
  logic              w_tc;
  logic              w_start_acc;
  logic              w_handshake;
  logic              w_last_pass;
  logic [CNT_BW-1:0] w_stream_last;
  logic [1:0]        w_nxt_cal;

  assign w_start_acc   = (r_state == ST_IDLE) && i_start;
  assign w_handshake   = (r_state == ST_OUT) && o_res_valid && i_res_ready;
  // Widened compare so pass_idx+1 cannot wrap when num_pass is at its max
  assign w_last_pass   = (({1'b0, o_pass_idx} + {{CNT_BW{1'b0}}, 1'b1}) == {1'b0, r_num_pass});
  // A zero pass length still streams for one cycle
  assign w_stream_last = (r_pass_len == '0) ? '0 : (r_pass_len - CNT_BW'(1));

  sched_phase_cnt #(
    .W (CNT_BW)
  ) u_phase_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .o_tc       (w_tc)
  );

  // Next-state logic; the phase counter is reloaded on every phase entry
  always_comb begin
    w_nxt_state = r_state;
    w_cnt_load  = 1'b0;
    w_cnt_val   = '0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          if (i_num_pass == '0) begin
            w_nxt_state = ST_DONE;
          end else begin
            w_nxt_state = ST_LOAD;
            w_cnt_load  = 1'b1;
            w_cnt_val   = LOAD_LAST;
          end
        end
      end
      ST_LOAD: begin
        if (w_tc) begin
          w_nxt_state = ST_STREAM;
          w_cnt_load  = 1'b1;
          w_cnt_val   = w_stream_last;
        end
      end
      ST_STREAM: begin
        if (w_tc) begin
          w_nxt_state = ST_DRAIN;
          w_cnt_load  = 1'b1;
          w_cnt_val   = DRAIN_LAST;
        end
      end
      ST_DRAIN: begin
        if (w_tc) begin
          w_nxt_state = ST_OUT;
        end
      end
      ST_OUT: begin
        if (w_handshake) begin
          if (w_last_pass) begin
            w_nxt_state = ST_DONE;
          end else begin
            w_nxt_state = ST_LOAD;
            w_cnt_load  = 1'b1;
            w_cnt_val   = LOAD_LAST;
          end
        end
      end
      ST_DONE: begin
        w_nxt_state = ST_IDLE;
      end
      default: begin
        w_nxt_state = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    w_nxt_cal = CAL_IDLE;
    case (w_nxt_state)
      ST_LOAD:   w_nxt_cal = CAL_LOAD;
      ST_STREAM: w_nxt_cal = CAL_STREAM;
      ST_DRAIN:  w_nxt_cal = CAL_DRAIN;
      default:   w_nxt_cal = CAL_IDLE;
    endcase
  end

  // Phase outputs are decoded from the next state so they are registered
  // yet line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_en_tf     <= 1'b0;
      o_cal_state <= CAL_IDLE;
      o_rd_en     <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      o_busy      <= (w_nxt_state == ST_LOAD) || (w_nxt_state == ST_STREAM) ||
                     (w_nxt_state == ST_DRAIN) || (w_nxt_state == ST_OUT);
      o_done      <= (w_nxt_state == ST_DONE);
      o_en_tf     <= (w_nxt_state == ST_LOAD) || (w_nxt_state == ST_STREAM) ||
                     (w_nxt_state == ST_DRAIN);
      o_cal_state <= w_nxt_cal;
      o_rd_en     <= (w_nxt_state == ST_LOAD) || (w_nxt_state == ST_STREAM);
    end
  end

  // Job configuration and pass index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_layer_state <= '0;
      r_num_pass    <= '0;
      r_pass_len    <= '0;
      o_pass_idx    <= '0;
    end else if (w_start_acc) begin
      o_layer_state <= i_layer_state;
      r_num_pass    <= i_num_pass;
      r_pass_len    <= i_pass_len;
      o_pass_idx    <= '0;
    end else if (w_handshake && !w_last_pass) begin
      o_pass_idx    <= o_pass_idx + CNT_BW'(1);
    end
  end

  // Result capture on the last DRAIN cycle; held until accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_res_data  <= '0;
      o_res_valid <= 1'b0;
    end else if ((r_state == ST_DRAIN) && w_tc) begin
      o_res_data  <= i_acc_pp;
      o_res_valid <= 1'b1;
    end else if (w_handshake) begin
      o_res_valid <= 1'b0;
    end
  end

`ifdef TILE_SCHED_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_stall_cnt <= '0;
    end else if (w_start_acc) begin
      o_stall_cnt <= '0;
    end else if ((r_state == ST_OUT) && o_res_valid && !i_res_ready &&
                 (o_stall_cnt != 16'hFFFF)) begin
      o_stall_cnt <= o_stall_cnt + 16'd1;
    end
  end
`endif

endmodule
